// File: rtl/fetch_pc_stage_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// instruction size and the value a cleared IF/ID instruction field holds.
package fetch_pc_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_stage_ifid_register.sv
// IF/ID pipeline register: load, hold, bubble and synchronous squash of
// {instr, pc, valid}. A squash clears valid but still lets the fields load.
module fetch_pc_stage_ifid_register
   import fetch_pc_stage_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              bubble,
   input  logic              clr,
   input  logic [31:0]       instr_in,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pc,
   output logic              valid
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr <= NOP_INSTR;
         pc    <= '0;
         valid <= 1'b0;
      end else begin
         if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
         end
         if (clr || bubble) begin
            valid <= 1'b0;
         end else if (load) begin
            valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch stage: PC/nPC pair with delayed-branch redirect, instruction-memory
// request FSM with a one-word hold buffer, and the IF/ID register.
//
// state | meaning
// IDLE  | first cycle after reset release, no request
// REQ   | request outstanding on imem, advance on ack with le_pc
// HOLD  | word acked during a stall is buffered, request dropped
module fetch_pc_stage
   import fetch_pc_stage_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              le_pc,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] target_addr,
   input  logic              ifid_clr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] npc,
   output logic [31:0]       ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic              ifid_valid
);

   localparam logic [1:0]        ST_IDLE = IDLE;
   localparam logic [1:0]        ST_REQ  = REQ;
   localparam logic [1:0]        ST_HOLD = HOLD;
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN   = ~ADDR_W'(3);

   logic [1:0]        state, state_nxt;
   logic [ADDR_W-1:0] pc_q, npc_q;
   logic [ADDR_W-1:0] pend_target, target_aligned, redirect_target;
   logic              pend_valid;
   logic [31:0]       hold_buf, fetch_word;
   logic              advance, bubble, capture;

   assign target_aligned = target_addr & ALIGN;

   always_comb begin
      state_nxt  = state;
      advance    = 1'b0;
      bubble     = 1'b0;
      capture    = 1'b0;
      fetch_word = imem_rdata;
      case (state)
         ST_IDLE: state_nxt = ST_REQ;
         ST_REQ: begin
            if (imem_ack) begin
               if (le_pc) begin
                  advance = 1'b1;
               end else begin
                  capture   = 1'b1;
                  state_nxt = ST_HOLD;
               end
            end else if (le_pc) begin
               bubble = 1'b1;
            end
         end
         ST_HOLD: begin
            fetch_word = hold_buf;
            if (le_pc) begin
               advance   = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Live redirect beats a pending one, which beats sequential flow.
   always_comb begin
      if (branch_taken) begin
         redirect_target = target_aligned;
      end else if (pend_valid) begin
         redirect_target = pend_target;
      end else begin
         redirect_target = npc_q + STEP;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         pc_q        <= RESET_PC;
         npc_q       <= RESET_PC + STEP;
         pend_valid  <= 1'b0;
         pend_target <= '0;
         hold_buf    <= NOP_INSTR;
      end else begin
         state <= state_nxt;
         if (capture) begin
            hold_buf <= imem_rdata;
         end
         if (advance) begin
            pc_q       <= npc_q;
            npc_q      <= redirect_target;
            pend_valid <= 1'b0;
         end else if (branch_taken) begin
            pend_valid  <= 1'b1;
            pend_target <= target_aligned;
         end
      end
   end

   assign imem_req  = (state == ST_REQ);
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign npc       = npc_q;

   fetch_pc_stage_ifid_register #(
      .ADDR_W (ADDR_W)
   ) u_ifid_register (
      .clk      (clk),
      .reset    (reset),
      .load     (advance),
      .bubble   (bubble),
      .clr      (ifid_clr),
      .instr_in (fetch_word),
      .pc_in    (pc_q),
      .instr    (ifid_instr),
      .pc       (ifid_pc),
      .valid    (ifid_valid)
   );

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage: a behavioural fetch model checked every
// cycle, plus literal expectations along the scenario.
module tb_fetch_pc_stage;

   logic        clk;
   logic        reset;
   logic        le_pc;
   logic        branch_taken;
   logic [31:0] target_addr;
   logic        ifid_clr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] npc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic        ifid_valid;

   int vectors     = 0;
   int miscompares = 0;

   fetch_pc_stage #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .le_pc        (le_pc),
      .branch_taken (branch_taken),
      .target_addr  (target_addr),
      .ifid_clr     (ifid_clr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .pc           (pc),
      .npc          (npc),
      .ifid_instr   (ifid_instr),
      .ifid_pc      (ifid_pc),
      .ifid_valid   (ifid_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Model: a fetcher that is either starting up, fetching, or sitting on a
   // buffered word; instructions move into decode when the hazard unit allows.
   logic [31:0] m_pc, m_npc, m_instr, m_ifpc, m_hold, m_ptgt, m_word, m_next;
   bit          m_valid, m_started, m_holding, m_pend, m_adv, m_was_fetching;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc = 32'h0; m_npc = 32'h4;
         m_instr = 32'h0; m_ifpc = 32'h0; m_valid = 1'b0;
         m_started = 1'b0; m_holding = 1'b0; m_pend = 1'b0; m_ptgt = 32'h0; m_hold = 32'h0;
      end else begin
         m_adv = 1'b0;
         m_word = imem_rdata;
         m_was_fetching = m_started && !m_holding;
         if (!m_started) begin
            m_started = 1'b1;
         end else if (m_holding) begin
            m_word = m_hold;
            if (le_pc) begin
               m_adv = 1'b1;
               m_holding = 1'b0;
            end
         end else if (imem_ack) begin
            if (le_pc) m_adv = 1'b1;
            else begin
               m_hold = imem_rdata;
               m_holding = 1'b1;
            end
         end
         if (m_adv) begin
            m_instr = m_word; m_ifpc = m_pc; m_valid = 1'b1;
            if (branch_taken) m_next = {target_addr[31:2], 2'b00};
            else if (m_pend) m_next = m_ptgt;
            else m_next = m_npc + 32'd4;
            m_pc = m_npc; m_npc = m_next; m_pend = 1'b0;
         end else begin
            if (branch_taken) begin
               m_pend = 1'b1;
               m_ptgt = {target_addr[31:2], 2'b00};
            end
            if (m_was_fetching && le_pc && !imem_ack) m_valid = 1'b0;
         end
         if (ifid_clr) m_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         chk("pc", pc, m_pc);
         chk("npc", npc, m_npc);
         chk("imem_addr", imem_addr, m_pc);
         chk("imem_req", {31'b0, imem_req}, {31'b0, m_started && !m_holding});
         chk("ifid_instr", ifid_instr, m_instr);
         chk("ifid_pc", ifid_pc, m_ifpc);
         chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
      end
   end

   bit          force_en = 1'b0;
   logic [31:0] force_word = 32'h0;

   task automatic step(input logic le, input logic ack, input logic bt,
                       input logic [31:0] tgt, input logic clr);
      le_pc = le; imem_ack = ack; branch_taken = bt; target_addr = tgt; ifid_clr = clr;
      imem_rdata = force_en ? force_word : word_of(m_pc);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; le_pc = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0;
      target_addr = 32'h0; ifid_clr = 1'b0; imem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_npc", npc, 32'h4);
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
      reset = 1'b1;

      // Sequential zero-wait stream
      step(1, 1, 0, 32'h0, 0);
      chk("idle_exit_req", {31'b0, imem_req}, 32'h1);
      chk("idle_exit_pc", pc, 32'h0);
      step(1, 1, 0, 32'h0, 0);
      chk("seq0_ifid_pc", ifid_pc, 32'h0);
      chk("seq0_instr", ifid_instr, 32'hC0DE_0000);
      step(1, 1, 0, 32'h0, 0);
      chk("seq1_ifid_pc", ifid_pc, 32'h4);

      // Taken branch with delay slot
      step(1, 1, 1, 32'h0000_0100, 0);
      chk("br_ifid_pc", ifid_pc, 32'h8);
      chk("br_npc", npc, 32'h100);
      step(1, 1, 0, 32'h0, 0);
      chk("slot_ifid_pc", ifid_pc, 32'hC);
      chk("slot_pc", pc, 32'h100);
      step(1, 1, 0, 32'h0, 0);
      chk("tgt_ifid_pc", ifid_pc, 32'h100);

      // Ack during stall: buffered, request dropped, IF/ID holds
      force_en = 1'b1; force_word = 32'hDEAD_BEEF;
      step(0, 1, 0, 32'h0, 0);
      force_en = 1'b0;
      chk("hold_req", {31'b0, imem_req}, 32'h0);
      step(0, 1, 0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 0);
      chk("hold_ifid_pc", ifid_pc, 32'h100);
      step(1, 0, 0, 32'h0, 0);
      chk("hold_release_instr", ifid_instr, 32'hDEAD_BEEF);
      chk("hold_release_pc", ifid_pc, 32'h104);
      chk("hold_release_req", {31'b0, imem_req}, 32'h1);

      // Pending redirect, newest wins, low bits dropped
      step(0, 0, 1, 32'h0000_0300, 0);
      step(0, 0, 1, 32'h0000_0203, 0);
      step(1, 0, 0, 32'h0, 0);
      chk("bubble_valid", {31'b0, ifid_valid}, 32'h0);
      chk("bubble_pc", pc, 32'h108);
      step(1, 1, 0, 32'h0, 0);
      chk("pend_npc", npc, 32'h200);
      chk("pend_ifid_pc", ifid_pc, 32'h108);

      // Wrap at the top of the address space, then squash
      step(1, 1, 1, 32'hFFFF_FFF8, 0);
      step(1, 1, 0, 32'h0, 0);
      chk("wrap_pc", pc, 32'hFFFF_FFF8);
      step(1, 1, 0, 32'h0, 0);
      chk("wrap_npc", npc, 32'h0);
      step(1, 1, 0, 32'h0, 0);
      chk("wrap_addr", imem_addr, 32'h0);
      step(1, 1, 0, 32'h0, 1);
      chk("clr_valid", {31'b0, ifid_valid}, 32'h0);
      chk("clr_pc_adv", pc, 32'h4);
      step(0, 0, 0, 32'h0, 1);
      chk("clr_stall_valid", {31'b0, ifid_valid}, 32'h0);

      // Asynchronous reset between edges, then late ack in IDLE
      le_pc = 1'b1; imem_ack = 1'b1; ifid_clr = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_pc", pc, 32'h0);
      chk("async_npc", npc, 32'h4);
      chk("async_req", {31'b0, imem_req}, 32'h0);
      chk("async_ifid_pc", ifid_pc, 32'h0);
      chk("async_instr", ifid_instr, 32'h0);
      chk("async_valid", {31'b0, ifid_valid}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      step(1, 1, 0, 32'h0, 0);
      chk("late_ack_valid", {31'b0, ifid_valid}, 32'h0);
      chk("late_ack_pc", pc, 32'h0);
      step(1, 1, 0, 32'h0, 0);
      chk("restart_ifid_pc", ifid_pc, 32'h0);
      chk("restart_valid", {31'b0, ifid_valid}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Fetch stage that owns the PC/nPC register pair and the IF/ID pipeline register. Consumes the branch-resolution result (`branch_taken`, `target_addr`) from the condition-handler / logic-box path. Drives the instruction-memory request handshake. Presents fetched instructions to decode with delayed-branch (nPC) semantics. It sits directly upstream of decode and downstream of the branch target mux.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; nPC resets to `RESET_PC + 4`.
- `ADDR_W`, default 32: width of PC, nPC, target and memory address.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; asserting it (low) clears all state immediately.
- `le_pc` input 1: advance enable from the hazard unit; 0 stalls PC, nPC and IF/ID.
- `branch_taken` input 1: redirect request, i.e. the logic-box output.
- `target_addr` input ADDR_W: redirect target from the branch mux; bits [1:0] are ignored and forced to 00.
- `ifid_clr` input 1: synchronous squash of the IF/ID valid bit.
- `imem_req` output 1: fetch request.
- `imem_addr` output ADDR_W: equals `pc`.
- `imem_ack` input 1: memory has returned `imem_rdata` this cycle.
- `imem_rdata` input 32: fetched instruction.
- `pc`, `npc` output ADDR_W: current PC/nPC registers.
- `ifid_instr` output 32, `ifid_pc` output ADDR_W, `ifid_valid` output 1: decode-stage register.

## Operation
- Reset values: `pc`=RESET_PC, `npc`=RESET_PC+4, `ifid_instr`=0, `ifid_pc`=0, `ifid_valid`=0, `imem_req`=0. Internal state: state=IDLE, pending redirect cleared, hold buffer empty.
- States:
  - IDLE (first cycle after reset release) → REQ unconditionally.
  - REQ: `imem_req`=1.
    - ack & `le_pc` → advance, stay REQ.
    - ack & !`le_pc` → capture `imem_rdata` into hold buffer, go HOLD.
    - no ack → stay REQ.
  - HOLD: `imem_req`=0; wait for `le_pc`=1, then advance using the buffered word and go REQ.
- Advance, one cycle:
  - IF/ID ← {word, `pc`, valid=1}.
  - `pc` ← `npc`.
  - `npc` ← redirect ? target : `npc`+4.
- Delayed-branch semantics: the instruction at the old `npc` (delay slot) is always fetched. A redirect never squashes IF/ID by itself.
- Redirect source priority:
  1. Live `branch_taken`.
  2. Pending redirect register.
  3. Sequential (`npc`+4).
- Pending redirect: `branch_taken` seen in a cycle with no advance is latched as {pend_valid, pend_target}. A newer `branch_taken` overwrites it. It is cleared when consumed by an advance.
- Bubble: `le_pc`=1 in REQ without ack → `ifid_valid` ← 0; PC/nPC hold.
- Stall: `le_pc`=0 → IF/ID holds all fields.
- `ifid_clr`=1 → `ifid_valid` ← 0 that cycle, overriding any load. PC/nPC advance still occurs if due.
- Arithmetic: `npc`+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0 with no flag.

## Timing
- `imem_addr` is combinational from the `pc` register. Zero-wait memory (ack in the same cycle as req) sustains one instruction per cycle.
- Latency: a word acked at edge N (with `le_pc`=1) is visible on `ifid_*` after edge N.
- `branch_taken` at edge N (with advance) → `npc`=target after N, `pc`=target after N+1, target instruction in IF/ID after N+2 (zero-wait).
- A HOLD exit advance occurs on the first edge with `le_pc`=1. The next request is issued the cycle after.
- Reset asserted mid-fetch: state returns to reset values asynchronously. A late `imem_ack` while in IDLE is ignored.

## Structure
- Shared package:
  - state enum {IDLE, REQ, HOLD}.
  - constant `INSTR_BYTES`=4.
  - NOP encoding 32'h0000_0000 for documentation of a cleared `ifid_instr`.
- One natural sub-module: `ifid_register` (load/hold/clear of {instr, pc, valid}). The FSM and the PC/nPC logic stay in the top.

## Test plan
- Reset release, ack held 1, `le_pc`=1 → `ifid_pc` sequence 0,4,8,12 on consecutive cycles; `pc` starts 0, `npc` 4.
- `branch_taken`=1, target 32'h0000_0100 while `pc`=8 → `ifid_pc` sequence 8, 12 (delay slot), 0x100.
- Ack arrives with `le_pc`=0 for 3 cycles, rdata 32'hDEAD_BEEF → `imem_req`=0 during HOLD; IF/ID unchanged; on release `ifid_instr`=DEADBEEF.
- `branch_taken` pulse (target 0x200) during stall → pending redirect applied at next advance; `npc`=0x200.
- `pc`=32'hFFFF_FFF8 sequential → `npc` wraps to 0, then fetch address 0; `ifid_clr`=1 with ack → `ifid_valid`=0.
- `reset` driven low mid-REQ between edges → outputs return to reset values immediately, without waiting for a clock edge.
